leaf_link_arbiter: RTL and testbench

// - Shares one inter-FPGA hub link between a leaf's NUM_SRC grid boundary FIFOs and its stage-controller FIFO.
// - Egress: round-robin picks one ready source, tags the word with its source ID and sends it on a registered output.
// - Ingress: decodes the ID field of each incoming hub word and routes it to the matching grid FIFO or the stage controller.
// - Sits between the planar-code grid / stage controller and the final hub FIFO; also reports in-flight traffic for deadlock detection.

---
 rtl/leaf_link_pkg.sv | 44 ++++
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/leaf_link_arbiter.sv | 153 +++++++++++++++
 tb/tb_leaf_link_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_link_pkg.sv
`default_nettype none
// ============================================================================
// Module : leaf_link_pkg
// Brief  : Shared ID-width helper, hub word pack/unpack and the stage-controller ID.
// Rev    : 1.0  initial release
// ============================================================================
package leaf_link_pkg;

  localparam int c_hub_max_width = 64;

  function automatic int link_id_width(input int n);
    return $clog2(n + 1);
  endfunction

  // The stage controller always takes the ID one past the last grid FIFO.
  function automatic int sc_id(input int num_src);
    return num_src;
  endfunction

  function automatic logic [c_hub_max_width-1:0] pack_hub_word(
    input logic [c_hub_max_width-1:0] id,
    input logic [c_hub_max_width-1:0] payload,
    input int                         data_width
  );
    return (id << data_width) | payload;
  endfunction

  function automatic logic [c_hub_max_width-1:0] unpack_hub_id(
    input logic [c_hub_max_width-1:0] word,
    input int                         data_width,
    input int                         id_width
  );
    return (word >> data_width) & ((c_hub_max_width'(1) << id_width) - c_hub_max_width'(1));
  endfunction

  function automatic logic [c_hub_max_width-1:0] unpack_hub_payload(
    input logic [c_hub_max_width-1:0] word,
    input int                         data_width
  );
    return word & ((c_hub_max_width'(1) << data_width) - c_hub_max_width'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : N-way round-robin arbiter; search starts one past the last winner.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import leaf_link_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  int               w_best_dist;

  // Distance from r_ptr+1 (mod N) ranks requesters; the smallest wins.
  always_comb begin
    w_found     = 1'b0;
    w_idx       = '0;
    w_best_dist = N;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (((i - int'(r_ptr) - 1 + N) % N) < w_best_dist)) begin
        w_found     = 1'b1;
        w_idx       = IDX_W'(i);
        w_best_dist = (i - int'(r_ptr) - 1 + N) % N;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = enable && w_found && (w_idx == IDX_W'(i));
    end
  end

  assign grant_idx   = w_idx;
  assign grant_valid = enable && w_found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= IDX_W'(N - 1);
    end else if (enable && w_found) begin
      r_ptr <= w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/leaf_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module : leaf_link_arbiter
// Brief  : Shares one hub link between grid boundary FIFOs and the stage controller.
// Rev    : 1.0  initial release
// ============================================================================
module leaf_link_arbiter
  import leaf_link_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ID_WIDTH       = link_id_width(NUM_SRC),
  parameter int HUB_FIFO_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] grid_out_data,
  input  logic [NUM_SRC-1:0]            grid_out_valid,
  output logic [NUM_SRC-1:0]            grid_out_ready,
  input  logic [DATA_WIDTH-1:0]         sc_out_data,
  input  logic                          sc_out_valid,
  output logic                          sc_out_ready,
  output logic [NUM_SRC*DATA_WIDTH-1:0] grid_in_data,
  output logic [NUM_SRC-1:0]            grid_in_valid,
  input  logic [NUM_SRC-1:0]            grid_in_ready,
  output logic [DATA_WIDTH-1:0]         sc_in_data,
  output logic                          sc_in_valid,
  input  logic                          sc_in_ready,
  output logic [HUB_FIFO_WIDTH-1:0]     hub_out_data,
  output logic                          hub_out_valid,
  input  logic                          hub_out_ready,
  input  logic [HUB_FIFO_WIDTH-1:0]     hub_in_data,
  input  logic                          hub_in_valid,
  output logic                          hub_in_ready,
  output logic                          has_flying_messages,
  output logic                          bad_id_error
);

  localparam int c_sc_id = sc_id(NUM_SRC);

  // ---------------- Egress ----------------
  logic [NUM_SRC:0]            w_req;
  logic [NUM_SRC:0]            w_grant;
  logic [ID_WIDTH-1:0]         w_grant_idx;
  logic                        w_grant_valid;
  logic                        w_slot_free;
  logic [DATA_WIDTH-1:0]       w_sel_data;
  logic [HUB_FIFO_WIDTH-1:0]   r_hub_out_data;
  logic                        r_hub_out_valid;

  assign w_req       = {sc_out_valid, grid_out_valid};
  assign w_slot_free = !r_hub_out_valid || hub_out_ready;

  rr_arbiter #(
    .N     (NUM_SRC + 1),
    .IDX_W (ID_WIDTH)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req         (w_req),
    .enable      (w_slot_free),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  assign grid_out_ready = w_grant[NUM_SRC-1:0];
  assign sc_out_ready   = w_grant[c_sc_id];

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) w_sel_data = grid_out_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    if (w_grant[c_sc_id]) w_sel_data = sc_out_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hub_out_valid <= 1'b0;
      r_hub_out_data  <= '0;
    end else if (w_slot_free) begin
      r_hub_out_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_hub_out_data <= HUB_FIFO_WIDTH'(pack_hub_word(c_hub_max_width'(w_grant_idx),
                                                        c_hub_max_width'(w_sel_data),
                                                        DATA_WIDTH));
      end
    end
  end

  assign hub_out_data  = r_hub_out_data;
  assign hub_out_valid = r_hub_out_valid;

  // ---------------- Ingress ----------------
  logic                  r_hold_valid;
  logic [ID_WIDTH-1:0]   r_hold_id;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_bad_id;
  logic                  w_dest_ready;
  logic                  w_delivered;
  logic                  w_capture;
  logic                  w_in_bad;
  logic [ID_WIDTH-1:0]   w_in_id;
  logic [DATA_WIDTH-1:0] w_in_payload;

  assign w_in_id      = ID_WIDTH'(unpack_hub_id(c_hub_max_width'(hub_in_data), DATA_WIDTH, ID_WIDTH));
  assign w_in_payload = DATA_WIDTH'(unpack_hub_payload(c_hub_max_width'(hub_in_data), DATA_WIDTH));
  assign w_in_bad     = w_in_id > ID_WIDTH'(c_sc_id);

  always_comb begin
    w_dest_ready = sc_in_ready && (r_hold_id == ID_WIDTH'(c_sc_id));
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_hold_id == ID_WIDTH'(i)) w_dest_ready = grid_in_ready[i];
    end
  end

  assign w_delivered  = r_hold_valid && w_dest_ready;
  assign hub_in_ready = !r_hold_valid || w_delivered;
  assign w_capture    = hub_in_valid && hub_in_ready;

  // Out-of-range IDs are consumed from the link but never occupy the hold reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_id    <= '0;
      r_hold_data  <= '0;
      r_bad_id     <= 1'b0;
    end else begin
      if (w_capture && !w_in_bad) begin
        r_hold_valid <= 1'b1;
        r_hold_id    <= w_in_id;
        r_hold_data  <= w_in_payload;
      end else if (w_delivered) begin
        r_hold_valid <= 1'b0;
      end
      if (w_capture && w_in_bad) r_bad_id <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ingress_slot
    assign grid_in_data[g*DATA_WIDTH +: DATA_WIDTH] = r_hold_data;
    assign grid_in_valid[g] = r_hold_valid && (r_hold_id == ID_WIDTH'(g));
  end

  assign sc_in_data   = r_hold_data;
  assign sc_in_valid  = r_hold_valid && (r_hold_id == ID_WIDTH'(c_sc_id));
  assign bad_id_error = r_bad_id;

  assign has_flying_messages = r_hub_out_valid | r_hold_valid | (|grid_out_valid) | sc_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_leaf_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_leaf_link_arbiter
// Brief  : Directed self-checking bench for leaf_link_arbiter (4 sources, 8b data).
// Rev    : 1.0  initial release
// ============================================================================
module tb_leaf_link_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DW      = 8;
  localparam int HW      = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_SRC*DW-1:0] grid_out_data;
  logic [NUM_SRC-1:0]    grid_out_valid;
  logic [NUM_SRC-1:0]    grid_out_ready;
  logic [DW-1:0]         sc_out_data;
  logic                  sc_out_valid;
  logic                  sc_out_ready;
  logic [NUM_SRC*DW-1:0] grid_in_data;
  logic [NUM_SRC-1:0]    grid_in_valid;
  logic [NUM_SRC-1:0]    grid_in_ready;
  logic [DW-1:0]         sc_in_data;
  logic                  sc_in_valid;
  logic                  sc_in_ready;
  logic [HW-1:0]         hub_out_data;
  logic                  hub_out_valid;
  logic                  hub_out_ready;
  logic [HW-1:0]         hub_in_data;
  logic                  hub_in_valid;
  logic                  hub_in_ready;
  logic                  has_flying_messages;
  logic                  bad_id_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  leaf_link_arbiter #(
    .NUM_SRC        (NUM_SRC),
    .DATA_WIDTH     (DW),
    .ID_WIDTH       (3),
    .HUB_FIFO_WIDTH (HW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .grid_out_data       (grid_out_data),
    .grid_out_valid      (grid_out_valid),
    .grid_out_ready      (grid_out_ready),
    .sc_out_data         (sc_out_data),
    .sc_out_valid        (sc_out_valid),
    .sc_out_ready        (sc_out_ready),
    .grid_in_data        (grid_in_data),
    .grid_in_valid       (grid_in_valid),
    .grid_in_ready       (grid_in_ready),
    .sc_in_data          (sc_in_data),
    .sc_in_valid         (sc_in_valid),
    .sc_in_ready         (sc_in_ready),
    .hub_out_data        (hub_out_data),
    .hub_out_valid       (hub_out_valid),
    .hub_out_ready       (hub_out_ready),
    .hub_in_data         (hub_in_data),
    .hub_in_valid        (hub_in_valid),
    .hub_in_ready        (hub_in_ready),
    .has_flying_messages (has_flying_messages),
    .bad_id_error        (bad_id_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    grid_out_data  = '0;
    grid_out_valid = '0;
    sc_out_data    = '0;
    sc_out_valid   = 1'b0;
    grid_in_ready  = '0;
    sc_in_ready    = 1'b0;
    hub_out_ready  = 1'b0;
    hub_in_data    = '0;
    hub_in_valid   = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_hub_out_valid", 32'(hub_out_valid), 32'd0);
    check_eq("rst_grid_in_valid", 32'(grid_in_valid), 32'd0);
    check_eq("rst_sc_in_valid",   32'(sc_in_valid),   32'd0);
    check_eq("rst_bad_id",        32'(bad_id_error),  32'd0);
    check_eq("rst_flying",        32'(has_flying_messages), 32'd0);
    check_eq("rst_hub_in_ready",  32'(hub_in_ready),  32'd1);

    // Single grid word: same-cycle grant, one-cycle latency to the hub reg.
    step();
    grid_out_valid = 4'b0001;
    grid_out_data  = 32'h0000_005A;
    hub_out_ready  = 1'b1;
    #1;
    check_eq("single_grant",    32'(grid_out_ready), 32'h1);
    check_eq("single_sc_ready", 32'(sc_out_ready),   32'd0);
    check_eq("single_flying",   32'(has_flying_messages), 32'd1);
    step();
    grid_out_valid = 4'b0000;
    check_eq("single_hub_valid", 32'(hub_out_valid), 32'd1);
    check_eq("single_hub_data",  32'(hub_out_data),  32'h005A);

    // Full contention: strict rotation 0..4 starting from a fresh pointer.
    pulse_reset();
    grid_out_data  = 32'h1312_1110;
    sc_out_data    = 8'h44;
    grid_out_valid = 4'b1111;
    sc_out_valid   = 1'b1;
    hub_out_ready  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq($sformatf("rr_word%0d", k), 32'(hub_out_data),
               (k % 5 == 4) ? 32'h0444 : 32'(((k % 5) << 8) | (8'h10 + k % 5)));
    end
    check_eq("rr_valid", 32'(hub_out_valid), 32'd1);

    // Back-pressure: slot stays full, no grants, word held steady.
    hub_out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("stall_grant%0d", k), 32'({sc_out_ready, grid_out_ready}), 32'd0);
      check_eq($sformatf("stall_data%0d", k),  32'(hub_out_data), 32'h0444);
      check_eq($sformatf("stall_flying%0d", k), 32'(has_flying_messages), 32'd1);
      step();
    end
    check_eq("stall_valid", 32'(hub_out_valid), 32'd1);
    grid_out_valid = '0;
    sc_out_valid   = 1'b0;
    hub_out_ready  = 1'b1;
    step();
    check_eq("drain_valid",  32'(hub_out_valid), 32'd0);
    check_eq("drain_flying", 32'(has_flying_messages), 32'd0);

    // Ingress to grid slot 2 with downstream stalled for 3 cycles.
    hub_in_data  = 16'h02C3;
    hub_in_valid = 1'b1;
    #1;
    check_eq("in_ready_empty", 32'(hub_in_ready), 32'd1);
    step();
    hub_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("in_valid%0d", k), 32'(grid_in_valid), 32'h4);
      check_eq($sformatf("in_data%0d", k),  32'(grid_in_data[2*DW +: DW]), 32'hC3);
      check_eq($sformatf("in_ready%0d", k), 32'(hub_in_ready), 32'd0);
      step();
    end
    // Delivery and next capture share one edge.
    grid_in_ready = 4'b0100;
    hub_in_data   = 16'h0411;
    hub_in_valid  = 1'b1;
    #1;
    check_eq("in_deliver_ready", 32'(hub_in_ready), 32'd1);
    step();
    grid_in_ready = 4'b0000;
    check_eq("sc_in_valid",   32'(sc_in_valid),   32'd1);
    check_eq("sc_in_data",    32'(sc_in_data),    32'h11);
    check_eq("sc_grid_valid", 32'(grid_in_valid), 32'd0);
    sc_in_ready = 1'b1;
    hub_in_data = 16'h0677;
    #1;
    check_eq("bad_in_ready", 32'(hub_in_ready), 32'd1);
    step();
    hub_in_valid = 1'b0;
    sc_in_ready  = 1'b0;
    check_eq("bad_sc_valid",   32'(sc_in_valid),   32'd0);
    check_eq("bad_grid_valid", 32'(grid_in_valid), 32'd0);
    check_eq("bad_flag",       32'(bad_id_error),  32'd1);
    step();
    check_eq("bad_sticky",     32'(bad_id_error),  32'd1);
    check_eq("bad_in_ready_idle", 32'(hub_in_ready), 32'd1);

    // Fill both hold regs, then reset asynchronously mid-cycle.
    grid_out_data  = 32'h0000_BB00;
    grid_out_valid = 4'b0010;
    hub_out_ready  = 1'b0;
    hub_in_data    = 16'h0155;
    hub_in_valid   = 1'b1;
    step();
    grid_out_valid = '0;
    hub_in_valid   = 1'b0;
    check_eq("full_hub_valid",  32'(hub_out_valid), 32'd1);
    check_eq("full_hub_data",   32'(hub_out_data),  32'h01BB);
    check_eq("full_grid_valid", 32'(grid_in_valid), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_hub_valid",  32'(hub_out_valid), 32'd0);
    check_eq("arst_grid_valid", 32'(grid_in_valid), 32'd0);
    check_eq("arst_bad_id",     32'(bad_id_error),  32'd0);
    step();
    reset          = 1'b0;
    grid_out_data  = 32'h0403_0201;
    grid_out_valid = 4'b1111;
    sc_out_valid   = 1'b1;
    hub_out_ready  = 1'b1;
    #1;
    check_eq("post_rst_grant", 32'({sc_out_ready, grid_out_ready}), 32'h01);
    step();
    check_eq("post_rst_word", 32'(hub_out_data), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
